// File: rtl/rom_loader_pkg.sv
// Shared types and default ioctl index codes for the ROM download router.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        FLUSH,
        HOLD
    } load_state_e;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // Counter width able to hold the value n itself (never narrower than 1).
    function automatic int unsigned count_width(input int unsigned n);
        return (n > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// One ROM window: registered hit strobe, window-local address and fill tracking.
module rom_region_decode #(
    parameter int unsigned     AW   = 25,
    parameter int unsigned     RAW  = 16,
    parameter logic [AW-1:0]   BASE = '0,
    parameter logic [AW-1:0]   SIZE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_valid_i,
    input  logic           clear_i,
    input  logic [AW-1:0]  addr_i,
    output logic           we_o,
    output logic [RAW-1:0] addr_o,
    output logic           loaded_o
);

    // One extra bit so BASE+SIZE cannot wrap at the top of the address space.
    localparam logic [AW:0]  LO       = {1'b0, BASE};
    localparam logic [AW:0]  HI       = {1'b0, BASE} + {1'b0, SIZE};
    localparam logic [RAW:0] SIZE_CNT = (RAW + 1)'(SIZE);

    logic           hit;
    logic [AW:0]    addr_x;
    logic           we_q, we_d;
    logic [RAW-1:0] addr_q, addr_d;
    logic [RAW:0]   cnt_q, cnt_d;
    logic           loaded_q, loaded_d;

    always_comb begin
        addr_x   = {1'b0, addr_i};
        hit      = wr_valid_i && (addr_x >= LO) && (addr_x < HI);
        we_d     = hit;
        addr_d   = hit ? RAW'(addr_i - BASE) : addr_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        if (clear_i) begin
            cnt_d    = '0;
            loaded_d = 1'b0;
        end else if (we_q) begin
            cnt_d = cnt_q + (RAW + 1)'(1);
            if (cnt_d == SIZE_CNT) begin
                loaded_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            we_q     <= we_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

    assign we_o     = we_q;
    assign addr_o   = addr_q;
    assign loaded_o = loaded_q;

endmodule

// File: rtl/rom_loader_router.sv
// ioctl download demultiplexer: ROM windows, DIP/mod capture and core reset sequencing.
module rom_loader_router
    import rom_loader_pkg::*;
#(
    parameter int unsigned               NUM_REGIONS = 4,
    parameter int unsigned               AW          = 25,
    parameter int unsigned               RAW         = 16,
    parameter logic [NUM_REGIONS*AW-1:0] REGION_BASE = {25'h1_0000, 25'h0_FF00, 25'h0_E000, 25'h0_0000},
    parameter logic [NUM_REGIONS*AW-1:0] REGION_SIZE = {25'h0_0100, 25'h0_0100, 25'h0_1000, 25'h0_8000},
    parameter logic [7:0]                ROM_INDEX   = IDX_ROM,
    parameter logic [7:0]                MOD_INDEX   = IDX_MOD,
    parameter logic [7:0]                DIP_INDEX   = IDX_DIP,
    parameter int unsigned               DIP_BYTES   = 8,
    parameter int unsigned               MOD_COUNT   = 8,
    parameter int unsigned               HOLD_CYCLES = 16
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       ioctl_download,
    input  logic [7:0]                 ioctl_index,
    input  logic                       ioctl_wr,
    input  logic [AW-1:0]              ioctl_addr,
    input  logic [7:0]                 ioctl_dout,
    output logic [NUM_REGIONS-1:0]     rom_we,
    output logic [NUM_REGIONS*RAW-1:0] rom_addr,
    output logic [7:0]                 rom_data,
    output logic [NUM_REGIONS-1:0]     region_loaded,
    output logic [DIP_BYTES*8-1:0]     dip,
    output logic [7:0]                 mod_byte,
    output logic [MOD_COUNT-1:0]       mod_onehot,
    output logic                       core_reset,
    output logic                       load_done
);

    localparam int unsigned      HW        = count_width(HOLD_CYCLES);
    localparam logic [HW-1:0]    HOLD_INIT = HW'(HOLD_CYCLES);

    load_state_e          state_q, state_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 load_done_q, load_done_d;
    logic [7:0]           rom_data_q, rom_data_d;
    logic [DIP_BYTES*8-1:0] dip_q, dip_d;
    logic [7:0]           mod_byte_q, mod_byte_d;
    logic [MOD_COUNT-1:0] mod_onehot_q, mod_onehot_d;
    logic                 rom_start;
    logic                 rom_wr;
    logic                 fill_clear;

    assign rom_start = ioctl_download && (ioctl_index == ROM_INDEX);
    assign rom_wr    = rom_start && ioctl_wr;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        load_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rom_start) state_d = LOADING;
            end
            LOADING: begin
                if (!ioctl_download) state_d = FLUSH;
            end
            FLUSH: begin
                state_d = HOLD;
                hold_d  = HOLD_INIT;
            end
            HOLD: begin
                // A restarted ROM download abandons the hold without signalling completion.
                if (rom_start) begin
                    state_d = LOADING;
                end else if (hold_q == HW'(1)) begin
                    state_d     = IDLE;
                    load_done_d = 1'b1;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        fill_clear = (state_d == LOADING) && (state_q != LOADING);
    end

    always_comb begin
        rom_data_d   = rom_wr ? ioctl_dout : rom_data_q;
        dip_d        = dip_q;
        mod_byte_d   = mod_byte_q;
        mod_onehot_d = '0;
        if (ioctl_wr && (ioctl_index == DIP_INDEX)) begin
            for (int unsigned k = 0; k < DIP_BYTES; k++) begin
                if (ioctl_addr == AW'(k)) dip_d[8*k +: 8] = ioctl_dout;
            end
        end
        if (ioctl_wr && (ioctl_index == MOD_INDEX)) begin
            mod_byte_d = ioctl_dout;
        end
        for (int unsigned m = 0; m < MOD_COUNT; m++) begin
            mod_onehot_d[m] = ({24'd0, mod_byte_q} == m);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= HOLD;
            hold_q       <= HOLD_INIT;
            load_done_q  <= 1'b0;
            rom_data_q   <= '0;
            dip_q        <= '0;
            mod_byte_q   <= '0;
            mod_onehot_q <= MOD_COUNT'(1);
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            load_done_q  <= load_done_d;
            rom_data_q   <= rom_data_d;
            dip_q        <= dip_d;
            mod_byte_q   <= mod_byte_d;
            mod_onehot_q <= mod_onehot_d;
        end
    end

    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
        rom_region_decode #(
            .AW   (AW),
            .RAW  (RAW),
            .BASE (REGION_BASE[r*AW +: AW]),
            .SIZE (REGION_SIZE[r*AW +: AW])
        ) u_decode (
            .clk        (clk_sys),
            .rst        (reset),
            .wr_valid_i (rom_wr),
            .clear_i    (fill_clear),
            .addr_i     (ioctl_addr),
            .we_o       (rom_we[r]),
            .addr_o     (rom_addr[r*RAW +: RAW]),
            .loaded_o   (region_loaded[r])
        );
    end

    assign rom_data   = rom_data_q;
    assign dip        = dip_q;
    assign mod_byte   = mod_byte_q;
    assign mod_onehot = mod_onehot_q;
    assign core_reset = (state_q != IDLE);
    assign load_done  = load_done_q;

endmodule

// File: tb/tb_rom_loader_router.sv
// Bench for rom_loader_router: directed scenarios plus randomized downloads against a window/fill model.
module tb_rom_loader_router;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 25;
    localparam int unsigned HOLD = 16;
    localparam logic [NR*AW-1:0] BASES   = {25'h1_0000, 25'h0_FF00, 25'h0_E000, 25'h0_0000};
    localparam logic [NR*AW-1:0] SIZES_A = {25'h0_0100, 25'h0_0100, 25'h0_1000, 25'h0_8000};
    localparam logic [NR*AW-1:0] SIZES_B = {25'h0_0100, 25'h0_0100, 25'h0_1000, 25'h0_F000};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dl  = 1'b0;
    logic [7:0]    idx = 8'd0;
    logic          wr  = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [7:0]    dout = 8'd0;

    logic [3:0]  a_we, b_we, a_ld, b_ld;
    logic [63:0] a_ra, b_ra, a_dip, b_dip;
    logic [7:0]  a_rd, b_rd, a_mod, b_mod, a_oh, b_oh;
    logic        a_core, b_core, a_done, b_done;

    rom_loader_router #(.REGION_BASE(BASES), .REGION_SIZE(SIZES_A)) dut_a (
        .clk_sys(clk), .reset(rst), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .rom_we(a_we), .rom_addr(a_ra), .rom_data(a_rd),
        .region_loaded(a_ld), .dip(a_dip), .mod_byte(a_mod), .mod_onehot(a_oh),
        .core_reset(a_core), .load_done(a_done));

    rom_loader_router #(.REGION_BASE(BASES), .REGION_SIZE(SIZES_B)) dut_b (
        .clk_sys(clk), .reset(rst), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .rom_we(b_we), .rom_addr(b_ra), .rom_data(b_rd),
        .region_loaded(b_ld), .dip(b_dip), .mod_byte(b_mod), .mod_onehot(b_oh),
        .core_reset(b_core), .load_done(b_done));

    always #5 clk = ~clk;

    // Reference model: windows as plain integers, fill as per-region byte counts.
    longint base_m[NR]    = '{64'h0, 64'hE000, 64'hFF00, 64'h1_0000};
    longint size_m[2][NR] = '{'{64'h8000, 64'h1000, 64'h100, 64'h100},
                              '{64'hF000, 64'h1000, 64'h100, 64'h100}};
    int     fill_m[2][NR];
    logic [7:0] dip_m[8];
    logic [7:0] mod_m;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_we(input int inst, input logic [AW-1:0] a);
        logic [3:0] v = '0;
        if (dl && idx == 8'd0)
            for (int r = 0; r < NR; r++)
                v[r] = (longint'(a) >= base_m[r]) && (longint'(a) < base_m[r] + size_m[inst][r]);
        return v;
    endfunction

    function automatic logic [3:0] exp_loaded(input int inst);
        logic [3:0] v = '0;
        for (int r = 0; r < NR; r++) v[r] = (fill_m[inst][r] >= size_m[inst][r]);
        return v;
    endfunction

    function automatic logic [63:0] exp_dip();
        logic [63:0] v = '0;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = dip_m[k];
        return v;
    endfunction

    function automatic logic [7:0] exp_onehot(input logic [7:0] m);
        return (m < 8) ? 8'(1 << m) : 8'd0;
    endfunction

    task automatic model_clear_fill();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < NR; r++) fill_m[i][r] = 0;
    endtask

    task automatic model_reset();
        model_clear_fill();
        for (int k = 0; k < 8; k++) dip_m[k] = 8'd0;
        mod_m = 8'd0;
    endtask

    // One ioctl byte, checked at the sample after the edge, then gap idle cycles.
    task automatic wr_byte(input logic [7:0] i, input logic [AW-1:0] a, input logic [7:0] d, input int gap);
        logic [3:0] ea, eb;
        idx = i; addr = a; dout = d;
        ea = exp_we(0, a);
        eb = exp_we(1, a);
        wr = 1'b1;
        step();
        wr = 1'b0;
        if (i == 8'd254 && a < 8) dip_m[a[2:0]] = d;
        if (i == 8'd1) mod_m = d;
        check_eq("rom_we_a", {60'd0, a_we}, {60'd0, ea});
        check_eq("rom_we_b", {60'd0, b_we}, {60'd0, eb});
        for (int r = 0; r < NR; r++) begin
            if (ea[r]) begin
                check_eq("rom_addr_a", {48'd0, a_ra[16*r +: 16]}, {48'd0, 16'(longint'(a) - base_m[r])});
                fill_m[0][r]++;
            end
            if (eb[r]) begin
                check_eq("rom_addr_b", {48'd0, b_ra[16*r +: 16]}, {48'd0, 16'(longint'(a) - base_m[r])});
                fill_m[1][r]++;
            end
        end
        if (ea != 0) check_eq("rom_data", {56'd0, a_rd}, {56'd0, d});
        check_eq("dip", a_dip, exp_dip());
        check_eq("mod_byte", {56'd0, a_mod}, {56'd0, mod_m});
        for (int g = 0; g < gap; g++) begin
            step();
            check_eq("we_idle_a", {60'd0, a_we}, 64'd0);
            check_eq("we_idle_b", {60'd0, b_we}, 64'd0);
        end
    endtask

    task automatic start_rom();
        dl = 1'b1; idx = 8'd0;
        model_clear_fill();
        step();
        check_eq("core_rst_load", {63'd0, a_core}, 64'd1);
    endtask

    // Counts edges until load_done; core_reset must stay high until then and drop with it.
    task automatic run_to_done(input string tag, input int exp_edges);
        int  edges = 0;
        int  early_low = 0;
        bit  seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            step();
            edges++;
            if (a_done) seen = 1'b1;
            else if (!a_core) early_low++;
        end
        check_eq({tag, "_seen"}, {63'd0, seen}, 64'd1);
        check_eq({tag, "_edges"}, 64'(edges), 64'(exp_edges));
        check_eq({tag, "_early_low"}, 64'(early_low), 64'd0);
        check_eq({tag, "_core_low"}, {63'd0, a_core}, 64'd0);
        step();
        check_eq({tag, "_pulse_end"}, {63'd0, a_done}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a;
        int r, kind, stop;
        longint off;

        model_reset();
        step();
        step();
        check_eq("rst_we", {60'd0, a_we}, 64'd0);
        check_eq("rst_addr", a_ra, 64'd0);
        check_eq("rst_data", {56'd0, a_rd}, 64'd0);
        check_eq("rst_loaded", {60'd0, a_ld}, 64'd0);
        check_eq("rst_dip", a_dip, 64'd0);
        check_eq("rst_mod", {56'd0, a_mod}, 64'd0);
        check_eq("rst_onehot", {56'd0, a_oh}, 64'd1);
        check_eq("rst_core", {63'd0, a_core}, 64'd1);
        check_eq("rst_done", {63'd0, a_done}, 64'd0);
        rst = 1'b0;
        run_to_done("por_hold", HOLD);

        // 1/2: window edge and overlap
        start_rom();
        wr_byte(8'd0, 25'h7FFF, 8'h3C, 1);
        wr_byte(8'd0, 25'h8000, 8'h4D, 0);
        check_eq("t1_miss_a", {60'd0, a_we}, 64'd0);
        step();
        wr_byte(8'd0, 25'hE005, 8'h5E, 1);
        // the bench-level overlap expectation, independent of the model
        wr_byte(8'd0, 25'hE005, 8'h5F, 0);
        check_eq("t2_ovl_we", {60'd0, b_we}, 64'b0011);
        check_eq("t2_ovl_addr1", {48'd0, b_ra[31:16]}, 64'h5);
        step();

        // 3: full region 2 stream then drop
        for (int k = 0; k < 256; k++) wr_byte(8'd0, 25'hFF00 + AW'(k), 8'($urandom), 0);
        dl = 1'b0;
        run_to_done("t3", 2 + HOLD);
        check_eq("t3_loaded2", {63'd0, a_ld[2]}, 64'd1);
        check_eq("t3_loaded_a", {60'd0, a_ld}, {60'd0, exp_loaded(0)});
        check_eq("t3_loaded_b", {60'd0, b_ld}, {60'd0, exp_loaded(1)});

        // 4: DIP capture never touches core_reset
        dl = 1'b1; idx = 8'd254;
        step();
        check_eq("t4_core0", {63'd0, a_core}, 64'd0);
        wr_byte(8'd254, 25'd3, 8'hA5, 1);
        check_eq("t4_core1", {63'd0, a_core}, 64'd0);
        wr_byte(8'd254, 25'd9, 8'h11, 1);
        check_eq("t4_core2", {63'd0, a_core}, 64'd0);
        check_eq("t4_dip3", {56'd0, a_dip[31:24]}, 64'hA5);

        // 5: mod decode
        idx = 8'd1;
        wr_byte(8'd1, 25'd0, 8'd2, 1);
        check_eq("t5_oh2", {56'd0, a_oh}, 64'b100);
        wr_byte(8'd1, 25'd0, 8'd9, 1);
        check_eq("t5_oh9", {56'd0, a_oh}, 64'd0);
        dl = 1'b0;
        step();

        // 6: reset mid-LOADING
        start_rom();
        for (int k = 0; k < 256; k++) wr_byte(8'd0, 25'h1_0000 + AW'(k), 8'($urandom), 0);
        step();
        check_eq("t6_loaded3", {60'd0, a_ld}, {60'd0, exp_loaded(0)});
        addr = 25'h1_0005; dout = 8'h77; wr = 1'b1;
        step();
        check_eq("t6_we_pre", {60'd0, a_we}, 64'b1000);
        rst = 1'b1;
        #1;
        check_eq("t6_we_async", {60'd0, a_we}, 64'd0);
        step();
        model_reset();
        check_eq("t6_we_edge", {60'd0, a_we}, 64'd0);
        check_eq("t6_loaded", {60'd0, a_ld}, 64'd0);
        wr = 1'b0; dl = 1'b0;
        rst = 1'b0;
        run_to_done("t6_hold", HOLD);

        // 7: restart during HOLD
        start_rom();
        for (int k = 0; k < 256; k++) wr_byte(8'd0, 25'hFF00 + AW'(k), 8'($urandom), 0);
        dl = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("t7_no_done_a", {63'd0, a_done}, 64'd0);
        end
        start_rom();
        for (int k = 0; k < 30; k++) begin
            step();
            check_eq("t7_no_done_b", {63'd0, a_done}, 64'd0);
        end
        check_eq("t7_core", {63'd0, a_core}, 64'd1);
        check_eq("t7_cleared", {60'd0, a_ld}, 64'd0);
        dl = 1'b0;
        run_to_done("t7", 2 + HOLD);

        // randomized ROM downloads with interleaved DIP bytes
        for (int it = 0; it < 6; it++) begin
            start_rom();
            if (it % 2 == 1) begin
                r = 2 + (it / 2) % 2;
                for (int k = 0; k < 256; k++)
                    wr_byte(8'd0, AW'(base_m[r] + k), 8'($urandom), $urandom_range(0, 1));
            end
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 7) == 0) begin
                    wr_byte(8'd254, AW'($urandom_range(0, 11)), 8'($urandom), $urandom_range(0, 2));
                    idx = 8'd0;
                    check_eq("rnd_core_load", {63'd0, a_core}, 64'd1);
                end else begin
                    r    = $urandom_range(0, 4);
                    kind = $urandom_range(0, 3);
                    if (r == 4) begin
                        a = AW'($urandom_range(0, 32'h1_FFFF));
                    end else begin
                        case (kind)
                            0: off = 0;
                            1: off = size_m[0][r] - 1;
                            2: off = size_m[0][r];
                            default: off = longint'($urandom_range(0, 32'(size_m[0][r] - 1)));
                        endcase
                        a = AW'(base_m[r] + off);
                    end
                    wr_byte(8'd0, a, 8'($urandom), $urandom_range(0, 2));
                end
            end
            dl = 1'b0;
            run_to_done("rnd", 2 + HOLD);
            check_eq("rnd_loaded_a", {60'd0, a_ld}, {60'd0, exp_loaded(0)});
            check_eq("rnd_loaded_b", {60'd0, b_ld}, {60'd0, exp_loaded(1)});

            dl = 1'b1;
            stop = $urandom_range(2, 5);
            for (int n = 0; n < stop; n++) begin
                if ($urandom_range(0, 1) == 0) begin
                    idx = 8'd1;
                    wr_byte(8'd1, '0, 8'($urandom_range(0, 12)), 1);
                    check_eq("rnd_onehot", {56'd0, a_oh}, {56'd0, exp_onehot(mod_m)});
                end else begin
                    idx = 8'd254;
                    wr_byte(8'd254, AW'($urandom_range(0, 15)), 8'($urandom), 1);
                end
                check_eq("rnd_core_idle", {63'd0, a_core}, 64'd0);
            end
            dl = 1'b0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
